// File: rtl/mem_writeback.sv
// Memory access / writeback stage: non-memory results retire in one cycle, loads and stores hold in WAIT until mem_ack.
// Define MEM_TIMEOUT_EN to abandon a request after 16 WAIT cycles and pulse mem_err.
module mem_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] imm_to_reg,
    input  logic [31:0] pc_link,
    input  logic [31:0] data_to_mem,
    input  logic        en_mem_wr,
    input  logic [1:0]  st_size,
    input  logic [2:0]  ld_code,
    input  logic        en_reg_wr,
    input  logic [4:0]  a2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        reg_wr_en,
    output logic [4:0]  reg_wr_addr,
    output logic [31:0] reg_wr_data,
    output logic        stall,
    output logic        misalign,
    output logic        mem_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_d;
    logic        req_d, we_d, rwe_d, mis_d;
    logic [31:0] addr_d, wdata_d, rwd_d;
    logic [3:0]  strb_d;
    logic [4:0]  rwa_d;
    logic [4:0]  cap_rd, cap_rd_d;
    logic [2:0]  cap_code, cap_code_d;
    logic [1:0]  cap_off, cap_off_d;
    logic        cap_wr, cap_wr_d;

    logic        is_store, is_load, is_mem, mis;
    logic [1:0]  sz;
    logic [31:0] st_data, src, ld_data;
    logic [3:0]  st_strb;
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign stall    = (state == WAIT);
    assign is_store = en_mem_wr;
    assign is_load  = !en_mem_wr && (ld_code >= 3'd2) && (ld_code <= 3'd6);
    assign is_mem   = is_store || is_load;

    // Access size: 0 byte, 1 half, 2 word; store size 3 is treated as word
    always_comb begin
        sz = 2'd2;
        if (is_store) begin
            unique case (st_size)
                2'd0:    sz = 2'd0;
                2'd1:    sz = 2'd1;
                default: sz = 2'd2;
            endcase
        end else begin
            unique case (ld_code)
                3'd3, 3'd5: sz = 2'd1;
                3'd4, 3'd6: sz = 2'd0;
                default:    sz = 2'd2;
            endcase
        end
    end

    assign mis = ((sz == 2'd1) && alu_result[0]) ||
                 ((sz == 2'd2) && (alu_result[1:0] != 2'b00));

    always_comb begin
        st_data = data_to_mem;
        st_strb = 4'b1111;
        unique case (sz)
            2'd0: begin
                st_data = {4{data_to_mem[7:0]}};
                st_strb = 4'b0001 << alu_result[1:0];
            end
            2'd1: begin
                st_data = {2{data_to_mem[15:0]}};
                st_strb = 4'b0011 << alu_result[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        src = alu_result;
        unique case (ld_code)
            3'd1:    src = imm_to_reg;
            3'd7:    src = pc_link;
            default: src = alu_result;
        endcase
    end

    assign byte_l = mem_rdata[{cap_off, 3'b000} +: 8];
    assign half_l = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        unique case (cap_code)
            3'd3:    ld_data = {{16{half_l[15]}}, half_l};
            3'd4:    ld_data = {{24{byte_l[7]}}, byte_l};
            3'd5:    ld_data = {16'h0, half_l};
            3'd6:    ld_data = {24'h0, byte_l};
            default: ld_data = mem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt, cnt_d;
    logic       err_d;
`endif

    always_comb begin
        state_d    = state;
        req_d      = mem_req;
        we_d       = mem_we;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        strb_d     = mem_wstrb;
        rwe_d      = 1'b0;
        rwa_d      = reg_wr_addr;
        rwd_d      = reg_wr_data;
        mis_d      = 1'b0;
        cap_rd_d   = cap_rd;
        cap_code_d = cap_code;
        cap_off_d  = cap_off;
        cap_wr_d   = cap_wr;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt;
        err_d      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (is_mem && mis) begin
                    mis_d = 1'b1;
                end else if (is_mem) begin
                    state_d    = WAIT;
                    req_d      = 1'b1;
                    we_d       = is_store;
                    addr_d     = {alu_result[31:2], 2'b00};
                    wdata_d    = is_store ? st_data : 32'h0;
                    strb_d     = is_store ? st_strb : 4'b0000;
                    cap_rd_d   = a2;
                    cap_code_d = ld_code;
                    cap_off_d  = alu_result[1:0];
                    cap_wr_d   = !is_store && en_reg_wr && (a2 != 5'd0);
`ifdef MEM_TIMEOUT_EN
                    cnt_d      = 4'd0;
`endif
                end else if (en_reg_wr && (a2 != 5'd0)) begin
                    rwe_d = 1'b1;
                    rwa_d = a2;
                    rwd_d = src;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    strb_d  = 4'b0000;
                    if (cap_wr) begin
                        rwe_d = 1'b1;
                        rwa_d = cap_rd;
                        rwd_d = ld_data;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == 4'hF) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    strb_d  = 4'b0000;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_wstrb   <= 4'b0000;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 5'd0;
            reg_wr_data <= 32'h0;
            misalign    <= 1'b0;
            cap_rd      <= 5'd0;
            cap_code    <= 3'd0;
            cap_off     <= 2'd0;
            cap_wr      <= 1'b0;
        end else begin
            state       <= state_d;
            mem_req     <= req_d;
            mem_we      <= we_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
            mem_wstrb   <= strb_d;
            reg_wr_en   <= rwe_d;
            reg_wr_addr <= rwa_d;
            reg_wr_data <= rwd_d;
            misalign    <= mis_d;
            cap_rd      <= cap_rd_d;
            cap_code    <= cap_code_d;
            cap_off     <= cap_off_d;
            cap_wr      <= cap_wr_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            mem_err <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            mem_err <= err_d;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule
